// File: rtl/module_ctrl_unit_pkg.sv
// Shared definitions for the instruction controller: opcodes, FSM states,
// default widths and the bit positions of the instruction fields.
package module_ctrl_unit_pkg;

    localparam int DATA_W    = 16;
    localparam int NREGS     = 4;
    localparam int REG_IDX_W = 2;
    localparam int INSTR_W   = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_DISP
    } state_t;

endpackage

// File: rtl/module_regfile.sv
// General register file: two asynchronous read ports, one write port and a
// synchronous clear-all that also serves as the reset path.
module module_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        clear,
    input  logic                                        we,
    input  logic [module_ctrl_unit_pkg::REG_IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0]                           wdata,
    input  logic [module_ctrl_unit_pkg::REG_IDX_W-1:0]  raddr_a,
    input  logic [module_ctrl_unit_pkg::REG_IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0]                           rdata_a,
    output logic [DATA_W-1:0]                           rdata_b
);
    import module_ctrl_unit_pkg::*;

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/module_ctrl_unit.sv
// Multi-cycle instruction controller: decodes one instruction at a time,
// drives an external combinational ALU and a handshaked display port.
module module_ctrl_unit #(
    parameter int DATA_W = module_ctrl_unit_pkg::DATA_W,
    parameter int NREGS  = module_ctrl_unit_pkg::NREGS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      instr_valid,
    output logic                                      instr_ready,
    input  logic [module_ctrl_unit_pkg::INSTR_W-1:0]  instr,
    output logic [2:0]                                alu_opcode,
    output logic signed [DATA_W-1:0]                  alu_a,
    output logic signed [DATA_W-1:0]                  alu_b,
    input  logic signed [DATA_W-1:0]                  alu_result,
    input  logic                                      alu_zero,
    output logic                                      disp_valid,
    input  logic                                      disp_ready,
    output logic [DATA_W-1:0]                         disp_data,
    output logic [1:0]                                disp_reg,
    output logic                                      zero_flag,
    output logic                                      busy
);
    import module_ctrl_unit_pkg::*;

    state_t                 state, state_nxt;
    logic [INSTR_W-1:0]     instr_q;
    logic [DATA_W-1:0]      result_q;
    logic                   zq;
    logic                   zero_q;
    logic [2:0]             opc_q;
    logic [REG_IDX_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]      imm_ext;
    logic [DATA_W-1:0]      rdata_a, rdata_b;
    logic                   rf_we, rf_clear;

    assign opc_q   = instr_q[OPC_MSB:OPC_LSB];
    assign rd_q    = instr_q[RD_MSB:RD_LSB];
    assign rs1_q   = instr_q[RS1_MSB:RS1_LSB];
    assign rs2_q   = instr_q[RS2_MSB:RS2_LSB];
    assign imm_ext = {{(DATA_W-IMM_W){instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign zero_flag   = zero_q;

    // Read ports always follow the latched instruction, so operands seen in
    // EXEC are the pre-writeback values even when rd aliases rs1/rs2.
    module_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .clear   (rf_clear),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (result_q),
        .raddr_a (rs1_q),
        .raddr_b (rs2_q),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        disp_valid = 1'b0;
        disp_data  = '0;
        disp_reg   = '0;
        rf_we      = 1'b0;
        rf_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (instr[OPC_MSB:OPC_LSB])
                        OP_CLEAR:   state_nxt = ST_WB;
                        OP_DISPLAY: state_nxt = ST_DISP;
                        default:    state_nxt = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                alu_opcode = opc_q;
                alu_a      = rdata_a;
                alu_b      = (opc_q == OP_ADD || opc_q == OP_SUB) ? rdata_b : imm_ext;
                state_nxt  = ST_WB;
            end
            ST_WB: begin
                if (opc_q == OP_CLEAR) begin
                    rf_clear = 1'b1;
                end else begin
                    rf_we = 1'b1;
                end
                state_nxt = ST_IDLE;
            end
            ST_DISP: begin
                disp_valid = 1'b1;
                disp_data  = rdata_a;
                disp_reg   = rs1_q;
                if (disp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            zq       <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ST_EXEC) begin
                result_q <= alu_result;
                zq       <= alu_zero;
            end
            if (state == ST_WB) begin
                zero_q <= (opc_q == OP_CLEAR) ? 1'b1 : zq;
            end
        end
    end

endmodule

// File: tb/tb_module_ctrl_unit.sv
// Directed bench for module_ctrl_unit: a vector table of single instructions
// plus hand sequences for operand drive, display stall, clear and reset.
module tb_module_ctrl_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               instr_valid;
    logic               instr_ready;
    logic [15:0]        instr;
    logic [2:0]         alu_opcode;
    logic signed [15:0] alu_a, alu_b, alu_result;
    logic               alu_zero;
    logic               disp_valid;
    logic               disp_ready;
    logic [15:0]        disp_data;
    logic [1:0]         disp_reg;
    logic               zero_flag;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  reg_idx;
        logic [15:0] exp_reg;
        logic        exp_zero;
        int          exp_low;
        string       name;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    module_ctrl_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_data   (disp_data),
        .disp_reg    (disp_reg),
        .zero_flag   (zero_flag),
        .busy        (busy)
    );

    // External ALU stand-in with 16-bit wrap-around arithmetic.
    always_comb begin
        case (alu_opcode)
            3'b000:         alu_result = alu_b;
            3'b001, 3'b010: alu_result = alu_a + alu_b;
            3'b011, 3'b100: alu_result = alu_a - alu_b;
            3'b101:         alu_result = alu_a * alu_b;
            default:        alu_result = '0;
        endcase
        alu_zero = (alu_result == 16'sd0);
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input int imm);
        return {op, rd, rs1, rs2, imm[6:0]};
    endfunction

    function automatic logic [15:0] readReg(input logic [1:0] idx);
        case (idx)
            2'd0:    return dut.u_regfile.regs[0];
            2'd1:    return dut.u_regfile.regs[1];
            2'd2:    return dut.u_regfile.regs[2];
            default: return dut.u_regfile.regs[3];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one instruction from IDLE and counts cycles with instr_ready low.
    task automatic applyStimulus(input logic [15:0] ins, output int low);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        low = 0;
        while (!instr_ready && low < 20) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        int low;

        vecs[0]  = '{enc(3'b000, 2'd1, 2'd0, 2'd0,   5), 2'd1, 16'h0005, 1'b0, 2, "load_r1_5"};
        vecs[1]  = '{enc(3'b010, 2'd1, 2'd1, 2'd0,  -5), 2'd1, 16'h0000, 1'b1, 2, "addi_r1_m5"};
        vecs[2]  = '{enc(3'b000, 2'd0, 2'd0, 2'd0, -64), 2'd0, 16'hFFC0, 1'b0, 2, "load_r0_m64"};
        vecs[3]  = '{enc(3'b000, 2'd2, 2'd0, 2'd0,   3), 2'd2, 16'h0003, 1'b0, 2, "load_r2_3"};
        vecs[4]  = '{enc(3'b011, 2'd3, 2'd0, 2'd2,   0), 2'd3, 16'hFFBD, 1'b0, 2, "sub_r3"};
        vecs[5]  = '{enc(3'b000, 2'd1, 2'd0, 2'd0,  63), 2'd1, 16'h003F, 1'b0, 2, "load_r1_63"};
        vecs[6]  = '{enc(3'b101, 2'd1, 2'd1, 2'd0,  63), 2'd1, 16'h0F81, 1'b0, 2, "mul_1"};
        vecs[7]  = '{enc(3'b101, 2'd1, 2'd1, 2'd0,  63), 2'd1, 16'hD0BF, 1'b0, 2, "mul_wrap"};
        vecs[8]  = '{enc(3'b001, 2'd2, 2'd2, 2'd2,   0), 2'd2, 16'h0006, 1'b0, 2, "add_alias"};
        vecs[9]  = '{enc(3'b100, 2'd2, 2'd2, 2'd0,   6), 2'd2, 16'h0000, 1'b1, 2, "subi_zero"};
        vecs[10] = '{enc(3'b001, 2'd0, 2'd3, 2'd1,   0), 2'd0, 16'hD07C, 1'b0, 2, "add_wrap"};
        vecs[11] = '{enc(3'b110, 2'd0, 2'd0, 2'd0,   0), 2'd3, 16'h0000, 1'b1, 1, "clear"};

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        disp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("rst_busy",  {31'd0, busy},        32'd0);
        checkOutput("rst_zero",  {31'd0, zero_flag},   32'd1);
        checkOutput("rst_disp",  {31'd0, disp_valid},  32'd0);
        for (int r = 0; r < 4; r++) checkOutput($sformatf("rst_r%0d", r), {16'd0, readReg(r[1:0])}, 32'd0);

        for (int i = 0; i < NVEC - 1; i++) begin
            applyStimulus(vecs[i].instr, low);
            checkOutput({vecs[i].name, "_reg"},  {16'd0, readReg(vecs[i].reg_idx)}, {16'd0, vecs[i].exp_reg});
            checkOutput({vecs[i].name, "_zero"}, {31'd0, zero_flag}, {31'd0, vecs[i].exp_zero});
            checkOutput({vecs[i].name, "_low"},  low, vecs[i].exp_low);
        end

        // Operand drive: ADDI r2 = r3 + (-3), watched through EXEC and WB.
        @(negedge clk);
        instr       = enc(3'b010, 2'd2, 2'd3, 2'd1, -3);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_opc", {29'd0, alu_opcode}, 32'd2);
        checkOutput("exec_a",   {16'd0, alu_a},      32'h0000FFBD);
        checkOutput("exec_b",   {16'd0, alu_b},      32'h0000FFFD);
        @(negedge clk);
        checkOutput("wb_alu_a", {16'd0, alu_a},      32'd0);
        checkOutput("wb_ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        checkOutput("addi_r2",  {16'd0, readReg(2'd2)}, 32'h0000FFBA);

        // Display of r3 with a 4-cycle stall; a competing instruction is ignored.
        disp_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_disp_ignored", {31'd0, disp_valid}, 32'd0);
        disp_ready  = 1'b0;
        instr       = enc(3'b111, 2'd0, 2'd3, 2'd0, 0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr = enc(3'b000, 2'd2, 2'd0, 2'd0, 7);
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("disp_valid_%0d", k), {31'd0, disp_valid}, 32'd1);
            checkOutput($sformatf("disp_data_%0d", k),  {16'd0, disp_data},  32'h0000FFBD);
            checkOutput($sformatf("disp_reg_%0d", k),   {30'd0, disp_reg},   32'd3);
            if (k == 5) begin
                instr_valid = 1'b0;
                disp_ready  = 1'b1;
            end
            @(negedge clk);
        end
        disp_ready = 1'b0;
        checkOutput("disp_done_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("disp_done_valid", {31'd0, disp_valid},  32'd0);
        checkOutput("disp_keep_r3",    {16'd0, readReg(2'd3)}, 32'h0000FFBD);
        checkOutput("disp_keep_r2",    {16'd0, readReg(2'd2)}, 32'h0000FFBA);
        checkOutput("disp_keep_zero",  {31'd0, zero_flag}, 32'd0);

        applyStimulus(vecs[NVEC-1].instr, low);
        checkOutput("clear_low",  low, vecs[NVEC-1].exp_low);
        checkOutput("clear_zero", {31'd0, zero_flag}, {31'd0, vecs[NVEC-1].exp_zero});
        for (int r = 0; r < 4; r++) checkOutput($sformatf("clear_r%0d", r), {16'd0, readReg(r[1:0])}, 32'd0);

        // Reset landing in EXEC of ADD r2 = r1 + r1 must drop the writeback.
        applyStimulus(enc(3'b000, 2'd1, 2'd0, 2'd0, 9), low);
        checkOutput("pre_rst_r1", {16'd0, readReg(2'd1)}, 32'd9);
        @(negedge clk);
        instr       = enc(3'b001, 2'd2, 2'd1, 2'd1, 0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("rst_exec_r2",    {16'd0, readReg(2'd2)}, 32'd0);
        checkOutput("rst_exec_r1",    {16'd0, readReg(2'd1)}, 32'd0);
        checkOutput("rst_exec_zero",  {31'd0, zero_flag}, 32'd1);
        checkOutput("rst_exec_disp",  {31'd0, disp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("post_rst_r2",    {16'd0, readReg(2'd2)}, 32'd0);
        checkOutput("post_rst_busy",  {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
